// File: rtl/mux_pkg.sv
// Shared constants for the N-to-1 scanning display/debug mux.
// Mode encodings and default geometry used by mux_nt1_scan.
package mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam int DEF_W     = 32;
  localparam int DEF_N     = 8;
  localparam int DEF_SW    = 3;
  localparam int DEF_DWELL = 16;

endpackage

// File: rtl/scan_dwell_cnt.sv
// Dwell counter for auto-scan: counts 0..DWELL-1 while enabled, tick marks the last cycle.
// tick is combinational from the count; the caller gates it with its own enable.
module scan_dwell_cnt #(
  parameter int DWELL = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] count_reg;

  assign tick = (count_reg == CW'(DWELL - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= tick ? '0 : count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/mux_nt1_scan.sv
// Registered N-to-1 W-bit selector with manual select or timed auto-scan.
// Optional MUX_SCAN_MASK_EN adds an en_mask port restricting which channels may be selected.
module mux_nt1_scan
  import mux_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int N     = DEF_N,
  parameter int SW    = DEF_SW,
  parameter int DWELL = DEF_DWELL
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  din,
  input  logic [SW-1:0]   sel,
  input  logic            mode,
  input  logic            hold,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N-1:0]    en_mask,
`endif
  output logic [W-1:0]    dout,
  output logic [SW-1:0]   cur_sel,
  output logic            sel_chg
);

  logic [N-1:0]  elig;
  logic [W-1:0]  chan [N];
  logic          scan;
  logic          tick;
  logic          sel_ok;
  logic [SW-1:0] adv_sel;
  logic [SW-1:0] sel_next;
  logic [W-1:0]  dout_next;
  logic [W-1:0]  dout_reg;
  logic [SW-1:0] cur_sel_reg;
  logic          sel_chg_reg;

`ifdef MUX_SCAN_MASK_EN
  assign elig = en_mask;
`else
  assign elig = '1;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign chan[gi] = din[gi*W +: W];
    end
  endgenerate

  assign scan = (mode == logic'(MODE_SCAN));

  // Counter sits at 0 in manual mode and freezes entirely while hold is high.
  scan_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (~scan & ~hold),
    .en   (scan & ~hold),
    .tick (tick)
  );

  always_comb begin
    int idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    sel_ok  = 1'b0;
    adv_sel = cur_sel_reg;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k) && elig[k]) sel_ok = 1'b1;
    end
    // Walk upward from cur_sel with wrap; offset N returns to cur_sel itself.
    for (int i = 1; i <= N; i++) begin
      idx = int'(cur_sel_reg) + i;
      if (idx >= N) idx = idx - N;
      for (int k = 0; k < N; k++) begin
        if (!found && idx == k && elig[k]) begin
          adv_sel = SW'(k);
          found   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_next = cur_sel_reg;
    if (scan) begin
      if (tick) sel_next = adv_sel;
    end else if (sel_ok) begin
      sel_next = sel;
    end
    dout_next = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_next == SW'(k)) dout_next = chan[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_reg    <= '0;
      cur_sel_reg <= '0;
      sel_chg_reg <= 1'b0;
    end else if (hold) begin
      sel_chg_reg <= 1'b0;
    end else begin
      dout_reg    <= dout_next;
      cur_sel_reg <= sel_next;
      sel_chg_reg <= (sel_next != cur_sel_reg);
    end
  end

  assign dout    = dout_reg;
  assign cur_sel = cur_sel_reg;
  assign sel_chg = sel_chg_reg;

endmodule

// File: tb/tb_mux_nt1_scan.sv
// Directed bench for mux_nt1_scan: an 8x32 DWELL=4 instance and a 6x8 DWELL=1 instance.
// Mask checks run only when MUX_SCAN_MASK_EN is defined.
module tb_mux_nt1_scan;

  logic          clk;
  logic          rst;
  logic [255:0]  din;
  logic [2:0]    sel;
  logic          mode;
  logic          hold;
  logic [31:0]   dout;
  logic [2:0]    cur_sel;
  logic          sel_chg;

  logic [47:0]   din1;
  logic [2:0]    sel1;
  logic          mode1;
  logic          hold1;
  logic [7:0]    dout1;
  logic [2:0]    cur_sel1;
  logic          sel_chg1;

`ifdef MUX_SCAN_MASK_EN
  logic [7:0]    en_mask;
  logic [5:0]    en_mask1;
`endif

  int total = 0;
  int bad   = 0;

  mux_nt1_scan #(.W(32), .N(8), .SW(3), .DWELL(4)) u0 (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .sel     (sel),
    .mode    (mode),
    .hold    (hold),
`ifdef MUX_SCAN_MASK_EN
    .en_mask (en_mask),
`endif
    .dout    (dout),
    .cur_sel (cur_sel),
    .sel_chg (sel_chg)
  );

  mux_nt1_scan #(.W(8), .N(6), .SW(3), .DWELL(1)) u1 (
    .clk     (clk),
    .rst     (rst),
    .din     (din1),
    .sel     (sel1),
    .mode    (mode1),
    .hold    (hold1),
`ifdef MUX_SCAN_MASK_EN
    .en_mask (en_mask1),
`endif
    .dout    (dout1),
    .cur_sel (cur_sel1),
    .sel_chg (sel_chg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] e_dout, input int e_sel, input int e_chg);
    check({tag, ".dout"}, dout, e_dout);
    check({tag, ".cur_sel"}, 32'(cur_sel), 32'(e_sel));
    check({tag, ".sel_chg"}, 32'(sel_chg), 32'(e_chg));
    $display("step %-14s dout=%h cur_sel=%0d sel_chg=%0d", tag, dout, cur_sel, sel_chg);
  endtask

  task automatic chk1(input string tag, input logic [7:0] e_dout, input int e_sel, input int e_chg);
    check({tag, ".dout"}, 32'(dout1), 32'(e_dout));
    check({tag, ".cur_sel"}, 32'(cur_sel1), 32'(e_sel));
    check({tag, ".sel_chg"}, 32'(sel_chg1), 32'(e_chg));
    $display("step %-14s dout=%h cur_sel=%0d sel_chg=%0d", tag, dout1, cur_sel1, sel_chg1);
  endtask

  task automatic set_ch(input int k, input logic [31:0] v);
    din[k*32 +: 32] = v;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 3'd0; hold = 1'b0;
    mode1 = 1'b0; sel1 = 3'd2; hold1 = 1'b0;
`ifdef MUX_SCAN_MASK_EN
    en_mask = 8'hFF; en_mask1 = 6'h3F;
`endif
    din = '0;
    for (int k = 0; k < 8; k++) set_ch(k, 32'h1000_0000 + 32'(k));
    set_ch(5, 32'hDEAD_BEEF);
    for (int k = 0; k < 6; k++) din1[k*8 +: 8] = 8'hA0 + 8'(k);

    // Reset
    step();
    chk("reset", 32'h0, 0, 0);
    chk1("reset1", 8'h00, 0, 0);

    // Manual select, live tracking, out-of-range ignore on N=6
    rst = 1'b0; sel = 3'd5;
    step();
    chk("man_sel5", 32'hDEAD_BEEF, 5, 1);
    chk1("n6_sel2", 8'hA2, 2, 1);
    sel1 = 3'd7; set_ch(5, 32'h1234_5678);
    step();
    chk("man_live5", 32'h1234_5678, 5, 0);
    chk1("n6_sel7_ign", 8'hA2, 2, 0);
    sel1 = 3'd6; sel = 3'd6;
    step();
    chk("man_sel6", 32'h1000_0006, 6, 1);
    chk1("n6_sel6_ign", 8'hA2, 2, 0);
    sel1 = 3'd5;
    step();
    chk("man_keep6", 32'h1000_0006, 6, 0);
    chk1("n6_sel5", 8'hA5, 5, 1);

    // Scan: u0 DWELL=4 from 6; u1 DWELL=1 wraps 5->0 on N=6
    mode = 1'b1; mode1 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("scan_dwell6", 32'h1000_0006, 6, 0);
      chk1("d1_scan", 8'hA0 + 8'(i - 1), i - 1, 1);
    end
    mode1 = 1'b0; sel1 = 3'd2;
    step();
    chk("scan_adv7", 32'h1000_0007, 7, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("scan_dwell7", 32'h1000_0007, 7, 0);
    end
    step();
    chk("scan_wrap0", 32'h1000_0000, 0, 1);

    // Hold mid-dwell at count=2
    step(); step();
    chk("scan_cnt2", 32'h1000_0000, 0, 0);
    hold = 1'b1; set_ch(0, 32'hCAFE_0000);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold", 32'h1000_0000, 0, 0);
    end
    hold = 1'b0;
    step();
    chk("release1", 32'hCAFE_0000, 0, 0);
    step();
    chk("release_adv", 32'h1000_0001, 1, 1);
    hold = 1'b1;
    step();
    chk("hold_chg0", 32'h1000_0001, 1, 0);

    // Scan -> manual takes effect on the same edge
    hold = 1'b0; mode = 1'b0; sel = 3'd3;
    step();
    chk("to_manual3", 32'h1000_0003, 3, 1);

    // rst wins over hold and clears the dwell count
    mode = 1'b1;
    step(); step();
    chk("scan_cnt2b", 32'h1000_0003, 3, 0);
    rst = 1'b1; hold = 1'b1;
    step();
    chk("rst_hold", 32'h0, 0, 0);
    rst = 1'b0; hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst", 32'hCAFE_0000, 0, 0);
    end
    step();
    chk("post_rst_adv", 32'h1000_0001, 1, 1);

`ifdef MUX_SCAN_MASK_EN
    rst = 1'b1;
    step();
    rst = 1'b0; en_mask = 8'b1000_0101;
    begin
      int seq [3];
      logic [31:0] dv [3];
      seq = '{2, 7, 0};
      dv  = '{32'h1000_0002, 32'h1000_0007, 32'hCAFE_0000};
      for (int j = 0; j < 3; j++) begin
        for (int i = 0; i < 3; i++) begin
          step();
          check("mask_dwell.cur_sel", 32'(cur_sel), (j == 0) ? 32'd0 : 32'(seq[j-1]));
        end
        step();
        chk("mask_adv", dv[j], seq[j], 1);
      end
    end
    en_mask = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("mask_none", 32'hCAFE_0000, 0, 0);
    end
    mode = 1'b0; en_mask = 8'b1000_0101; sel = 3'd1;
    step();
    chk("mask_man_ign", 32'hCAFE_0000, 0, 0);
    sel = 3'd2;
    step();
    chk("mask_man_ok", 32'h1000_0002, 2, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
